// File: rtl/piradip_sample_player_pkg.sv
// Shared types for the AXI4-Stream sample player.
// Mode and FSM state encodings plus the lane-count helper.
package piradip_sample_player_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_LOOP    = 2'd1,
    MODE_NPASS   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int lanes(input int sw);
    return sw / 32;
  endfunction

endpackage

// File: rtl/piradip_sample_ram.sv
// Simple dual-port sample RAM, one stream beat per word.
// 32-bit lane write enables, registered read data.
module piradip_sample_ram
  import piradip_sample_player_pkg::*;
#(
  parameter int STREAM_WIDTH = 256,
  parameter int DEPTH_LOG2   = 10
) (
  input  logic                      clk,
  input  logic [lanes(STREAM_WIDTH)-1:0] we_i,
  input  logic [DEPTH_LOG2-1:0]     waddr_i,
  input  logic [31:0]               wdata_i,
  input  logic                      re_i,
  input  logic [DEPTH_LOG2-1:0]     raddr_i,
  output logic [STREAM_WIDTH-1:0]   rdata_o
);

  localparam int LANES = lanes(STREAM_WIDTH);

  logic [STREAM_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  // lane-granular write port
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we_i[l]) begin
        mem_q[waddr_i][l*32 +: 32] <= wdata_i;
      end
    end
  end

  // one-cycle registered read
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/piradip_axis_sample_player.sv
// AXI4-Stream sample playback engine with window/loop/N-pass modes.
// Define PIRADIP_SAMPLE_PLAYER_TLAST_EN to mark the last beat of each pass.
module piradip_axis_sample_player
  import piradip_sample_player_pkg::*;
#(
  parameter int STREAM_WIDTH = 256,
  parameter int DEPTH_LOG2   = 10,
  parameter int PASS_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic [DEPTH_LOG2+$clog2(STREAM_WIDTH/32)-1:0] wr_addr,
  input  logic [31:0]             wr_data,
  input  logic [DEPTH_LOG2-1:0]   cfg_first,
  input  logic [DEPTH_LOG2-1:0]   cfg_last,
  input  logic [1:0]              cfg_mode,
  input  logic [PASS_WIDTH-1:0]   cfg_passes,
  input  logic                    start,
  input  logic                    stop,
  output logic                    busy,
  output logic                    done,
  output logic [STREAM_WIDTH-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast
);

  localparam int LANES = lanes(STREAM_WIDTH);
  localparam int LW    = $clog2(LANES);
  localparam int AW    = DEPTH_LOG2;

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [AW-1:0]   first_q, first_d;
  logic [AW-1:0]   last_q, last_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [PASS_WIDTH-1:0] passes_q, passes_d;
  logic [PASS_WIDTH-1:0] pass_q, pass_d;
  logic            flush_q, flush_d;
  logic            done_q, done_d;
  logic            rvld_q;
  logic [1:0]      cnt_q, cnt_d;
  logic [STREAM_WIDTH-1:0] ent0_q, ent1_q;
  logic [STREAM_WIDTH-1:0] rdata;
  logic [LANES-1:0] we;

  logic rd_en, pop, push, flush_now, room;
  logic at_last, final_pass;
  logic ld0, ld1, sh;

  assign we = wr_en ? (LANES'(1) << wr_addr[LW-1:0]) : '0;

  piradip_sample_ram #(
    .STREAM_WIDTH(STREAM_WIDTH),
    .DEPTH_LOG2  (DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(wr_addr[AW+LW-1:LW]),
    .wdata_i(wr_data),
    .re_i   (rd_en),
    .raddr_i(ptr_q),
    .rdata_o(rdata)
  );

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign m_tvalid = (cnt_q != 2'd0);
  assign m_tdata  = ent0_q;

  // next-state, read issue and output buffer control
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    first_d  = first_q;
    last_d   = last_q;
    ptr_d    = ptr_q;
    passes_d = passes_q;
    pass_d   = pass_q;
    flush_d  = flush_q;
    done_d   = 1'b0;
    rd_en    = 1'b0;
    ld0      = 1'b0;
    ld1      = 1'b0;
    sh       = 1'b0;
    pop       = m_tvalid && m_tready;
    flush_now = flush_q || (state_q == RUN && stop);
    push      = rvld_q && !flush_now;
    room      = ({1'b0, cnt_q} + {2'b0, rvld_q}
                 - {2'b0, pop}) < 3'd2;
    at_last   = (ptr_q == last_q);
    unique case (mode_q)
      MODE_LOOP:  final_pass = 1'b0;
      MODE_NPASS: final_pass =
        (pass_q == passes_q - PASS_WIDTH'(1));
      default:    final_pass = 1'b1;
    endcase
    unique case (cnt_q)
      2'd0: ld0 = push;
      2'd1: begin
        if (pop) ld0 = push;
        else     ld1 = push;
      end
      default: begin
        sh  = pop;
        ld1 = push;
      end
    endcase
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    if (flush_now) begin
      cnt_d = (m_tvalid && !pop) ? 2'd1 : 2'd0;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          first_d  = cfg_first;
          last_d   = cfg_last;
          ptr_d    = cfg_first;
          pass_d   = '0;
          flush_d  = 1'b0;
          mode_d   = (cfg_mode == 2'd3) ?
                     MODE_ONESHOT : mode_e'(cfg_mode);
          passes_d = (cfg_passes == '0) ?
                     PASS_WIDTH'(1) : cfg_passes;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          flush_d = 1'b1;
          state_d = DRAIN;
        end else if (room) begin
          rd_en = 1'b1;
          if (at_last) begin
            ptr_d  = first_q;
            pass_d = pass_q + PASS_WIDTH'(1);
            if (final_pass) state_d = DRAIN;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_d == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mode_q   <= MODE_ONESHOT;
      first_q  <= '0;
      last_q   <= '0;
      ptr_q    <= '0;
      passes_q <= '0;
      pass_q   <= '0;
      flush_q  <= 1'b0;
      done_q   <= 1'b0;
      rvld_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      first_q  <= first_d;
      last_q   <= last_d;
      ptr_q    <= ptr_d;
      passes_q <= passes_d;
      pass_q   <= pass_d;
      flush_q  <= flush_d;
      done_q   <= done_d;
      rvld_q   <= rd_en;
      cnt_q    <= cnt_d;
    end
  end

  // two-entry output buffer, entry 0 is the presented beat
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      if (ld0)     ent0_q <= rdata;
      else if (sh) ent0_q <= ent1_q;
      if (ld1)     ent1_q <= rdata;
    end
  end

`ifdef PIRADIP_SAMPLE_PLAYER_TLAST_EN
  logic rlast_q, lst0_q, lst1_q;

  // pass-boundary flag travels alongside each beat
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rlast_q <= 1'b0;
      lst0_q  <= 1'b0;
      lst1_q  <= 1'b0;
    end else begin
      rlast_q <= rd_en && at_last;
      if (ld0)     lst0_q <= rlast_q;
      else if (sh) lst0_q <= lst1_q;
      if (ld1)     lst1_q <= rlast_q;
    end
  end

  assign m_tlast = lst0_q;
`else
  assign m_tlast = 1'b0;
`endif

endmodule
